// File: rtl/grey_gen_chk_if.sv
// Bundle of the Gray-code generator's control, count and loopback-checker signals.
// master drives the counter controls and loop_in; slave is the grey_gen_chk side.
interface grey_gen_chk_if #(
    parameter int unsigned pWIDTH = 8,
    parameter int unsigned pDEPTH = 8
);
    localparam int unsigned LatW = $clog2(pDEPTH);

    logic              en;
    logic              dir;
    logic              load;
    logic [pWIDTH-1:0] load_val;
    logic [pWIDTH-1:0] bin_out;
    logic [pWIDTH-1:0] gray_out;
    logic              wrap;
    logic [pWIDTH-1:0] loop_in;
    logic              locked;
    logic [LatW-1:0]   lat;
    logic [7:0]        err_cnt;
    logic              gray_err;

    modport master (
        output en, dir, load, load_val, loop_in,
        input  bin_out, gray_out, wrap, locked, lat, err_cnt, gray_err
    );

    modport slave (
        input  en, dir, load, load_val, loop_in,
        output bin_out, gray_out, wrap, locked, lat, err_cnt, gray_err
    );
endinterface

// File: rtl/grey_gen_chk.sv
// Up/down binary counter with registered Gray output and, when GREY_CHECK_EN is defined,
// a loopback checker that locks onto the return latency and counts mismatches.
module grey_gen_chk #(
    parameter int unsigned pWIDTH = 8,
    parameter int unsigned pDEPTH = 8,
    parameter int unsigned pLOCK  = 4
) (
    input logic           clk,
    input logic           rst,
    grey_gen_chk_if.slave bus
);
    localparam int unsigned LatW = $clog2(pDEPTH);
    localparam logic [pWIDTH-1:0] AllOnes = '1;

    logic [pWIDTH-1:0] bin_q, bin_d, gray_q;
    logic              wrap_q, wrap_d;

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            bin_d = bus.load_val;
        end else if (bus.en) begin
            if (bus.dir) begin
                bin_d  = bin_q - pWIDTH'(1);
                wrap_d = (bin_q == '0);
            end else begin
                bin_d  = bin_q + pWIDTH'(1);
                wrap_d = (bin_q == AllOnes);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= bin_d ^ (bin_d >> 1);
            wrap_q <= wrap_d;
        end
    end

    assign bus.bin_out  = bin_q;
    assign bus.gray_out = gray_q;
    assign bus.wrap     = wrap_q;

`ifdef GREY_CHECK_EN
    localparam int unsigned RunW   = $clog2(pLOCK + 1);
    localparam int unsigned GuardW = $clog2(pDEPTH + 1);

    typedef enum logic [1:0] {StSearch, StLocked, StSlip} state_e;

    state_e            state_q;
    logic [pWIDTH-1:0] hist_q [1:pDEPTH-1];
    logic [pWIDTH-1:0] hist   [pDEPTH];
    logic [pWIDTH-1:0] loop_prev_q;
    logic [RunW-1:0]   run_q;
    logic              prev_hit_q;
    logic [LatW-1:0]   prev_tap_q;
    logic [LatW-1:0]   lat_q;
    logic [7:0]        err_q;
    logic              locked_q;
    logic              gray_err_q;
    logic [GuardW-1:0] guard_q;
    logic              tap_hit;
    logic [LatW-1:0]   tap;
    logic              lat_match;

    always_comb begin
        hist[0] = gray_q;
        for (int k = 1; k < int'(pDEPTH); k++) begin
            hist[k] = hist_q[k];
        end
    end

    // Scan from the deepest tap down so the lowest matching tap wins.
    always_comb begin
        tap_hit = 1'b0;
        tap     = '0;
        for (int k = int'(pDEPTH) - 1; k >= 0; k--) begin
            if (bus.loop_in == hist[k]) begin
                tap_hit = 1'b1;
                tap     = LatW'(k);
            end
        end
    end

    assign lat_match = (bus.loop_in == hist[lat_q]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k < int'(pDEPTH); k++) begin
                hist_q[k] <= '0;
            end
            state_q     <= StSearch;
            loop_prev_q <= '0;
            run_q       <= '0;
            prev_hit_q  <= 1'b0;
            prev_tap_q  <= '0;
            lat_q       <= '0;
            err_q       <= '0;
            locked_q    <= 1'b0;
            gray_err_q  <= 1'b0;
            guard_q     <= GuardW'(1);
        end else begin
            hist_q[1] <= gray_q;
            for (int k = 2; k < int'(pDEPTH); k++) begin
                hist_q[k] <= hist_q[k-1];
            end
            loop_prev_q <= bus.loop_in;
            prev_hit_q  <= tap_hit;
            prev_tap_q  <= tap;

            // A load makes a legitimate multi-bit jump that reaches loop_in within pDEPTH cycles.
            if (bus.load) begin
                guard_q <= GuardW'(pDEPTH);
            end else if (guard_q != '0) begin
                guard_q <= guard_q - GuardW'(1);
            end
            if (guard_q == '0 && $countones(bus.loop_in ^ loop_prev_q) > 1) begin
                gray_err_q <= 1'b1;
            end

            unique case (state_q)
                StSearch: begin
                    if (run_q == RunW'(pLOCK)) begin
                        state_q  <= StLocked;
                        locked_q <= 1'b1;
                        lat_q    <= prev_tap_q;
                        run_q    <= '0;
                    end else if (tap_hit && prev_hit_q && tap == prev_tap_q && bus.en) begin
                        run_q <= run_q + RunW'(1);
                    end else begin
                        run_q <= tap_hit ? RunW'(1) : '0;
                    end
                end
                StLocked: begin
                    if (!lat_match) begin
                        state_q <= StSlip;
                        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                    end
                end
                StSlip: begin
                    if (lat_match) begin
                        state_q <= StLocked;
                    end else begin
                        state_q  <= StSearch;
                        locked_q <= 1'b0;
                        run_q    <= '0;
                        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                    end
                end
                default: begin
                    state_q  <= StSearch;
                    locked_q <= 1'b0;
                    run_q    <= '0;
                end
            endcase
        end
    end

    assign bus.locked   = locked_q;
    assign bus.lat      = lat_q;
    assign bus.err_cnt  = err_q;
    assign bus.gray_err = gray_err_q;
`else
    logic unused_chk;
    assign unused_chk = ^{bus.loop_in, 4'(pLOCK)};

    assign bus.locked   = 1'b0;
    assign bus.lat      = '0;
    assign bus.err_cnt  = '0;
    assign bus.gray_err = 1'b0;
`endif
endmodule

// File: doc/grey_gen_chk.md
# grey_gen_chk

Parametrised Gray-code generator with an integrated loopback checker for the greycode tile. It counts up or down in binary, supports a synchronous load, and drives the Gray encoding on a registered output. A returned copy of that code comes back on `loop_in`. The optional checker measures the loopback latency in clocks, locks onto it, then counts mismatches and any non-Gray (multi-bit) transitions. It replaces the fixed-width, test-only counter path with a version generalised in width, history depth and direction.

## Interface
- `pWIDTH`, 8: counter and code width in bits; legal range 2..16.
- `pDEPTH`, 8: number of history taps searched for latency.
  - Legal range 2..16; must be a power of two and ≤ 2^pWIDTH.
- `pLOCK`, 4: consecutive same-tap matches required to lock; legal range 1..15.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `en`  in  1  advance the counter by one step this cycle.
- `dir`  in  1  count direction: 0 = up, 1 = down.
- `load`  in  1  load `load_val` (binary) this cycle; has priority over `en`.
- `load_val`  in  pWIDTH  binary value to load.
- `bin_out`  out  pWIDTH  registered binary count.
- `gray_out`  out  pWIDTH  registered Gray code, equal to `bin_out ^ (bin_out >> 1)`.
- `wrap`  out  1  one-cycle pulse on the cycle after the count wraps, in either direction.
- `loop_in`  in  pWIDTH  returned Gray code.
- `locked`  out  1  latency lock is acquired.
- `lat`  out  $clog2(pDEPTH)  measured latency in clocks; valid while `locked`=1.
- `err_cnt`  out  8  number of mismatches while locked; saturates at 255.
- `gray_err`  out  1  sticky flag: `loop_in` changed by more than one bit between consecutive cycles.

## Operation
- Counter priority: `rst` > `load` > `en`.
  - `load`: `bin_out` takes `load_val`; no `wrap` pulse.
  - `en` with `dir`=0: add 1 modulo 2^pWIDTH. `wrap` pulses on the transition from all-ones to 0.
  - `en` with `dir`=1: subtract 1 modulo 2^pWIDTH. `wrap` pulses on the transition from 0 to all-ones.
  - `bin_out` and `gray_out` are both registered and update on the same edge. The next Gray value is computed from the next binary value.
- History: `hist[0]` is `gray_out` itself; `hist[k]` is `gray_out` delayed by k clocks, for k = 1..pDEPTH-1. The history shifts every cycle, independent of `en`.
- Tap search: each cycle, find the lowest k with `loop_in == hist[k]`. If no tap matches, the result is no-match.
- Lock FSM has three states:
  - SEARCH
    - A match at the same k as the previous cycle, with `en`=1, increments the run counter.
    - A different k, a no-match, or `en`=0 resets the run to 1 on a match, or to 0 on no-match.
    - When the run reaches pLOCK, latch `lat`=k and move to LOCKED.
  - LOCKED
    - Compare `loop_in` against `hist[lat]` every cycle.
    - A mismatch increments `err_cnt` (saturating) and moves to SLIP.
  - SLIP
    - A match at `hist[lat]` returns to LOCKED.
    - A mismatch increments `err_cnt`, clears `locked`, clears the run and moves to SEARCH. `lat` holds its last value.
- `locked` = 1 in LOCKED and SLIP.
- `load` while locked causes no special handling. The pipeline carries the discontinuity through, and `loop_in` still matches `hist[lat]`.
- `gray_err`: set when the Hamming distance between `loop_in` and its previous-cycle value is > 1. It is cleared only by `rst`.
  - This check is disabled on the first cycle after reset and on the `pDEPTH` cycles following a `load`.
- Reset values: `bin_out`=0, `gray_out`=0, `wrap`=0, `locked`=0, `lat`=0, `err_cnt`=0, `gray_err`=0. History is 0, FSM is SEARCH, run is 0.
- `rst` mid-operation discards lock, history and counts on that edge.

## Timing
- `en` (or `load`) sampled at edge N gives the new `bin_out`/`gray_out` after edge N. `wrap` is asserted during the cycle after edge N.
- For a loopback with d registers (`loop_in` = `gray_out` delayed d), the FSM locks with `lat`=d.
  - `locked` rises after edge pLOCK+d+1 counted from the first `en`, given `en` held high.
- A mismatch is reflected in `err_cnt` on the next edge. Lock is lost after 2 consecutive mismatches.
- `en`=0 while locked is legal: the history keeps shifting, so matches continue.

## Configuration
- `GREY_CHECK_EN` defined: the history, tap search, lock FSM, `err_cnt` and `gray_err` are built.
- `GREY_CHECK_EN` undefined: only the counter is built.
  - `locked`, `lat`, `err_cnt` and `gray_err` are tied to 0.
  - `loop_in` is ignored.

## Test plan
- Counter, pWIDTH=8, up: reset, then `en`=1 for 256 cycles.
  - `gray_out` steps 0x00, 0x01, 0x03, 0x02, …; 0xFF maps to 0x80.
  - `wrap` pulses exactly once, when `bin_out` returns to 0x00.
- Down and load: `load_val`=0x05 with `load`=1 and `en`=1 together.
  - Next `bin_out`=0x05 (load wins).
  - Then `dir`=1, `en`=1 for 6 cycles: 0x04, …, 0x00, 0xFF, with `wrap`=1 after the 0xFF step.
- Latency lock, pLOCK=4: loop `gray_out` through 3 registers into `loop_in`, `en`=1.
  - `locked`=1 with `lat`=3 within 8 cycles; `err_cnt` stays 0 for 1000 cycles.
- Slip: while locked, force one cycle of `loop_in`=~expected.
  - `err_cnt`=1, `locked` stays 1.
  - Two consecutive forced mismatches: `err_cnt`=3 in total, `locked`=0, then relock with `lat`=3.
- Gray-error check: drive `loop_in` 0x00 then 0x03.
  - `gray_err`=1 and it stays set until `rst`.
  - Mid-run `rst`: every output returns to its reset value on the next edge.
- Build without `GREY_CHECK_EN`, same stimulus as the lock test: `locked`, `lat`, `err_cnt` and `gray_err` are constantly 0, and the counter behaviour is unchanged.
